// File: rtl/round_countdown_timer_pkg.sv
// Shared types and helpers for the round countdown timer: FSM state, BCD digit type and
// digit clamping/conversion functions.
package round_countdown_timer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StPause   = 2'd2,
        StExpired = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t clamp_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input bcd_t tens, input bcd_t ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer; chained through borrow to build a multi-digit down counter.
module bcd_digit_dec
    import round_countdown_timer_pkg::*;
(
    input  bcd_t digit_in,
    input  logic borrow_in,
    output bcd_t digit_out,
    output logic borrow_out
);

    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out = digit_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/round_countdown_timer.sv
// Game-round countdown timer: two BCD digits decremented once per divider tick while running.
// Optional blinking low-time warning is built when ROUND_TIMER_WARN_EN is defined.
module round_countdown_timer
    import round_countdown_timer_pkg::*;
`ifdef ROUND_TIMER_WARN_EN
#(
    parameter int unsigned WARN_SEC = 10
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expire_pulse,
    output logic       warn
);

    state_e state_q, state_d;
    bcd_t   tens_q, tens_d, ones_q, ones_d;
    bcd_t   dec_tens, dec_ones;
    logic   ones_borrow, tens_borrow;
    logic   expire_q, expire_d;

    bcd_digit_dec u_ones_dec (
        .digit_in   (ones_q),
        .borrow_in  (1'b1),
        .digit_out  (dec_ones),
        .borrow_out (ones_borrow)
    );

    bcd_digit_dec u_tens_dec (
        .digit_in   (tens_q),
        .borrow_in  (ones_borrow),
        .digit_out  (dec_tens),
        .borrow_out (tens_borrow)
    );

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        expire_d = 1'b0;
        if (clear) begin
            state_d = StIdle;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (load) begin
            state_d = StIdle;
            tens_d  = clamp_bcd(load_tens);
            ones_d  = clamp_bcd(load_ones);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && ((tens_q != 4'd0) || (ones_q != 4'd0))) state_d = StRun;
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPause;
                    end else if (tick) begin
                        // A borrow out of the tens digit would mean wrapping; treat it as expiry.
                        if (tens_borrow || ((dec_tens == 4'd0) && (dec_ones == 4'd0))) begin
                            tens_d   = 4'd0;
                            ones_d   = 4'd0;
                            state_d  = StExpired;
                            expire_d = 1'b1;
                        end else begin
                            tens_d = dec_tens;
                            ones_d = dec_ones;
                        end
                    end
                end
                StPause: begin
                    if (start) state_d = StRun;
                end
                StExpired: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            expire_q <= expire_d;
        end
    end

    assign sec_tens     = tens_q;
    assign sec_ones     = ones_q;
    assign running      = (state_q == StRun);
    assign done         = (state_q == StExpired);
    assign expire_pulse = expire_q;

`ifdef ROUND_TIMER_WARN_EN
    logic blink_q, blink_d, do_dec;

    assign do_dec = !clear && !load && (state_q == StRun) && !pause && tick;

    // Threshold is judged on the value the digits take this cycle.
    always_comb begin
        blink_d = 1'b0;
        if ((state_d == StRun) && (32'(bcd_to_bin(tens_d, ones_d)) <= WARN_SEC)) begin
            blink_d = do_dec ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_q <= 1'b0;
        else        blink_q <= blink_d;
    end

    assign warn = blink_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_countdown_timer.sv
// Directed self-checking bench for round_countdown_timer.
module tb_round_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
    logic [3:0] sec_tens, sec_ones;
    logic       running, done, expire_pulse, warn;

    int n_checks = 0;
    int n_fail   = 0;

    round_countdown_timer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .clear        (clear),
        .load         (load),
        .load_tens    (load_tens),
        .load_ones    (load_ones),
        .start        (start),
        .pause        (pause),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .running      (running),
        .done         (done),
        .expire_pulse (expire_pulse),
        .warn         (warn)
    );

    always #5 clk = ~clk;

    // Apply one cycle of commands at the next rising edge, sample 1 ns after it.
    task automatic step(input logic t, input logic c, input logic l, input logic s,
                        input logic p, input logic [3:0] lt, input logic [3:0] lo);
        tick = t; clear = c; load = l; start = s; pause = p;
        load_tens = lt; load_ones = lo;
        @(posedge clk);
        #1;
        tick = 0; clear = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({sec_tens, sec_ones, running, done, expire_pulse, warn} !== 12'h000) begin
            $display("FAIL reset_state: got %h%h r%b d%b p%b w%b, want 00 all 0",
                     sec_tens, sec_ones, running, done, expire_pulse, warn);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_round();
        logic [7:0] exp_d;
        logic       exp_w;
        int         v;
        step(0, 0, 1, 0, 0, 4'd1, 4'd2);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h12, 1'b0}) begin
            $display("FAIL load_12: got %h%h r%b, want 12 r0", sec_tens, sec_ones, running);
            n_fail++;
        end
        step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h12) begin
            $display("FAIL idle_tick_ignored: got %h%h, want 12", sec_tens, sec_ones);
            n_fail++;
        end
        step(0, 0, 0, 1, 0, 4'd0, 4'd0);
        n_checks++;
        if (running !== 1'b1) begin
            $display("FAIL start_run: running=%b, want 1", running);
            n_fail++;
        end
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 0, 0, 4'd0, 4'd0);
            v = 12 - i;
            exp_d = {4'(v / 10), 4'(v % 10)};
`ifdef ROUND_TIMER_WARN_EN
            exp_w = (v >= 1 && v <= 10) ? 1'((11 - v) % 2) : 1'b0;
`else
            exp_w = 1'b0;
`endif
            n_checks++;
            if ({sec_tens, sec_ones} !== exp_d || expire_pulse !== (i == 12) ||
                running !== (i != 12) || done !== (i == 12) || warn !== exp_w) begin
                $display("FAIL countdown_%0d: got %h%h p%b r%b d%b w%b, want %h p%b r%b d%b w%b",
                         i, sec_tens, sec_ones, expire_pulse, running, done, warn,
                         exp_d, (i == 12), (i != 12), (i == 12), exp_w);
                n_fail++;
            end
        end
        step(1, 0, 0, 1, 1, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, done, expire_pulse, running} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL expired_hold: got %h%h d%b p%b r%b, want 00 d1 p0 r0",
                     sec_tens, sec_ones, done, expire_pulse, running);
            n_fail++;
        end
    endtask

    task automatic test_borrow_pause();
        step(0, 0, 1, 0, 0, 4'd3, 4'd0);
        step(0, 0, 0, 1, 0, 4'd0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h29) begin
            $display("FAIL borrow_30_29: got %h%h, want 29", sec_tens, sec_ones);
            n_fail++;
        end
        step(1, 0, 0, 0, 1, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h29, 1'b0}) begin
            $display("FAIL pause_hold: got %h%h r%b, want 29 r0", sec_tens, sec_ones, running);
            n_fail++;
        end
        step(0, 0, 0, 1, 0, 4'd0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h28, 1'b1}) begin
            $display("FAIL resume_28: got %h%h r%b, want 28 r1", sec_tens, sec_ones, running);
            n_fail++;
        end
        step(0, 0, 0, 0, 1, 4'd0, 4'd0);
        step(1, 0, 0, 1, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h28, 1'b1}) begin
            $display("FAIL start_tick_pause: got %h%h r%b, want 28 r1", sec_tens, sec_ones, running);
            n_fail++;
        end
        step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h27) begin
            $display("FAIL first_tick_after_start: got %h%h, want 27", sec_tens, sec_ones);
            n_fail++;
        end
    endtask

    task automatic test_clamp();
        step(0, 0, 1, 0, 0, 4'hF, 4'hF);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h99) begin
            $display("FAIL clamp_ff: got %h%h, want 99", sec_tens, sec_ones);
            n_fail++;
        end
        step(0, 0, 1, 0, 0, 4'd5, 4'hC);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h59) begin
            $display("FAIL clamp_5c: got %h%h, want 59", sec_tens, sec_ones);
            n_fail++;
        end
        step(0, 0, 1, 0, 0, 4'd0, 4'd0);
        step(1, 0, 0, 1, 0, 4'd0, 4'd0);
        n_checks++;
        if ({running, done, expire_pulse, sec_tens, sec_ones} !== 11'h000) begin
            $display("FAIL start_at_zero: got r%b d%b p%b %h%h, want r0 d0 p0 00",
                     running, done, expire_pulse, sec_tens, sec_ones);
            n_fail++;
        end
    endtask

    task automatic test_priority();
        step(0, 0, 1, 0, 0, 4'd0, 4'd5);
        step(0, 0, 0, 1, 0, 4'd0, 4'd0);
        step(1, 1, 0, 1, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, running, done, expire_pulse} !== 11'h000) begin
            $display("FAIL clear_priority: got %h%h r%b d%b p%b, want 00 r0 d0 p0",
                     sec_tens, sec_ones, running, done, expire_pulse);
            n_fail++;
        end
        step(1, 0, 1, 1, 0, 4'd2, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h20, 1'b0}) begin
            $display("FAIL load_over_start: got %h%h r%b, want 20 r0", sec_tens, sec_ones, running);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 1, 0, 0, 4'd4, 4'd2);
        step(0, 0, 0, 1, 0, 4'd0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sec_tens, sec_ones, running, done, expire_pulse, warn} !== 12'h000) begin
            $display("FAIL async_reset: got %h%h r%b d%b p%b w%b, want 00 all 0",
                     sec_tens, sec_ones, running, done, expire_pulse, warn);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 4'd0, 4'd0);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== 9'h000) begin
            $display("FAIL tick_after_reset: got %h%h r%b, want 00 r0", sec_tens, sec_ones, running);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_borrow_pause();
        test_clamp();
        test_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
